fwd_hazard_tracker: RTL

//  Parametrised forwarding and load-use hazard unit for the RV32I pipeline.
//  - Successor to the fixed 3-way forward select: tracks DEPTH in-flight producers past EX.
//  - Drives a forward select per source operand of the instruction in EX.
//  - Requests a load-use stall when the youngest matching producer's data is not ready.
//  - Counts hazard stall cycles for performance reporting.

---
 rtl/fwd_hazard_tracker.sv | 77 +++++++
 1 files changed

// File: rtl/fwd_hazard_tracker.sv
// Forwarding select and load-use hazard detection for the instruction in EX,
// tracking DEPTH in-flight producers past EX plus a saturating stall counter.
module fwd_hazard_tracker #(
  parameter  int NUM_SRC    = 2,
  parameter  int DEPTH      = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int REG_ADDR_W = 5,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 freeze_i,
  input  logic                                 flush_i,
  input  logic                                 ex_valid_i,
  input  logic [REG_ADDR_W-1:0]                ex_rd_i,
  input  logic                                 ex_wr_i,
  input  logic                                 ex_is_load_i,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   src_addr_i,
  output logic [NUM_SRC-1:0][SEL_W-1:0]        fwd_sel_o,
  output logic                                 load_use_stall_o,
  output logic [CNT_W-1:0]                     stall_cnt_o
);

  logic [DEPTH-1:0]                  r_valid;
  logic [DEPTH-1:0]                  r_is_load;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  r_rd;
  logic [CNT_W-1:0]                  r_cnt;

  logic [NUM_SRC-1:0][SEL_W-1:0]     w_sel;
  logic [NUM_SRC-1:0]                w_not_ready;
  logic                              w_bubble;

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int j = 0; j < NUM_SRC; j++) begin
      w_sel[j]       = '0;
      w_not_ready[j] = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_valid[k] && (r_rd[k] == src_addr_i[j]) && (src_addr_i[j] != '0)) begin
          w_sel[j]       = SEL_W'(k + 1);
          w_not_ready[j] = r_is_load[k] && (k < LOAD_LAT);
        end
      end
    end
  end

  assign fwd_sel_o        = w_sel;
  assign load_use_stall_o = ex_valid_i && !flush_i && (|w_not_ready);
  assign stall_cnt_o      = r_cnt;
  assign w_bubble         = flush_i || load_use_stall_o;

  // NOTE: sequential state uses non-blocking assignments only, so the shift
  // reads every entry's old value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= '0;
      r_is_load <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
    end else if (!freeze_i) begin
      r_valid[0]   <= ex_valid_i && ex_wr_i && (ex_rd_i != '0) && !w_bubble;
      r_rd[0]      <= ex_rd_i;
      r_is_load[0] <= ex_is_load_i;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k]   <= r_valid[k-1];
        r_rd[k]      <= r_rd[k-1];
        r_is_load[k] <= r_is_load[k-1];
      end
      if (load_use_stall_o && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
